// File: rtl/irb_pkg.sv
// Shared types and default sizing for the inverted-residual-block external-memory arbiter.
package irb_pkg;

  localparam int unsigned ARB_N_REQ     = 3;
  localparam int unsigned ARB_BURST_MAX = 16;
  localparam int unsigned ARB_ADDR_W    = 32;
  localparam int unsigned ARB_DATA_W    = 32;

  typedef enum logic [1:0] {
    REQ_DMA_RD,
    REQ_DMA_WR,
    REQ_CFG
  } req_id_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned OW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [OW-1:0]    idx,
  output logic             any
);

  logic          found;
  logic [OW-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = OW'((32'(ptr) + 32'(i)) % N_REQ);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/extmem_arbiter.sv
// Round-robin, burst-locked arbiter for the single external-memory port.
// Optional per-requester completed-beat counters when ARB_STATS_EN is defined.
module extmem_arbiter
  import irb_pkg::*;
#(
  parameter int unsigned N_REQ     = ARB_N_REQ,
  parameter int unsigned BURST_MAX = ARB_BURST_MAX,
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned DATA_W    = ARB_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        wr,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*DATA_W-1:0] wdata_i,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        valid_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    request_extmem,
  output logic                    write_extmem,
  output logic [ADDR_W-1:0]       addr_extmem,
  output logic [DATA_W-1:0]       w_data,
  input  logic                    valid_extmem,
  input  logic [DATA_W-1:0]       data_extmem,
`ifdef ARB_STATS_EN
  output logic [N_REQ*32-1:0]     stat_beats,
`endif
  output logic                    err_spurious
);

  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  arb_state_t     state;
  logic [OW-1:0]  ptr;
  logic [OW-1:0]  owner;
  logic [CW-1:0]  beat_cnt;
  logic [OW-1:0]  pick_idx;
  logic           pick_any;
  logic           beat_done;
  logic           leave_busy;

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  for (genvar k = 0; k < int'(N_REQ); k++) begin : g_unpack
    assign addr_arr[k]  = addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = wdata_i[k*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign beat_done  = (state == ARB_BUSY) && valid_extmem;
  // Last beat, burst cap reached, or owner withdrew its request.
  assign leave_busy = (beat_done && (last[owner] || (beat_cnt == CW'(BURST_MAX - 1))))
                    || !req[owner];

  // Port mux driven from the registered owner; quiet outside BUSY.
  always_comb begin
    request_extmem = 1'b0;
    write_extmem   = 1'b0;
    addr_extmem    = '0;
    w_data         = '0;
    if (state == ARB_BUSY) begin
      request_extmem = req[owner];
      write_extmem   = wr[owner];
      addr_extmem    = addr_arr[owner];
      w_data         = wdata_arr[owner];
    end
  end

  assign valid_o = gnt & {N_REQ{valid_extmem}};
  assign rdata_o = data_extmem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB_IDLE;
      ptr          <= '0;
      owner        <= '0;
      beat_cnt     <= '0;
      gnt          <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (valid_extmem && (state != ARB_BUSY)) begin
        err_spurious <= 1'b1;
      end
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            owner <= pick_idx;
            gnt   <= N_REQ'(1) << pick_idx;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (beat_done) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
          if (leave_busy) begin
            gnt   <= '0;
            state <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          beat_cnt <= '0;
          ptr      <= (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] stat_q [N_REQ];

  // Saturating completed-beat counters, one per requester.
  for (genvar k = 0; k < int'(N_REQ); k++) begin : g_stat
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stat_q[k] <= '0;
      end else if (valid_o[k] && (stat_q[k] != '1)) begin
        stat_q[k] <= stat_q[k] + 32'd1;
      end
    end
    assign stat_beats[k*32 +: 32] = stat_q[k];
  end
`endif

endmodule

// File: tb/tb_extmem_arbiter.sv
// Directed self-checking bench for extmem_arbiter (default N_REQ=3, BURST_MAX=16).
module tb_extmem_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, wr, last;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [N-1:0]    gnt, valid_o;
  logic [DW-1:0]   rdata_o;
  logic            request_extmem, write_extmem;
  logic [AW-1:0]   addr_extmem;
  logic [DW-1:0]   w_data;
  logic            valid_extmem;
  logic [DW-1:0]   data_extmem;
  logic            err_spurious;
`ifdef ARB_STATS_EN
  logic [N*32-1:0] stat_beats;
`endif

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  extmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .wr             (wr),
    .last           (last),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .gnt            (gnt),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .request_extmem (request_extmem),
    .write_extmem   (write_extmem),
    .addr_extmem    (addr_extmem),
    .w_data         (w_data),
    .valid_extmem   (valid_extmem),
    .data_extmem    (data_extmem),
`ifdef ARB_STATS_EN
    .stat_beats     (stat_beats),
`endif
    .err_spurious   (err_spurious)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req          = '0;
    wr           = '0;
    last         = '0;
    addr_i       = {32'h0000_0300, 32'h0000_0200, 32'h0000_0010};
    wdata_i      = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    valid_extmem = 1'b0;
    data_extmem  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #1;
    vec++;
    if ({gnt, request_extmem, err_spurious} !== '0) begin
      bad++;
      $display("FAIL reset_asserted: gnt=%b req_ext=%b err=%b, expected 0", gnt, request_extmem, err_spurious);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++;
      if ({gnt, valid_o, request_extmem, write_extmem, addr_extmem, w_data, err_spurious, rdata_o} !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: gnt=%b vo=%b req_ext=%b wr_ext=%b addr=%h wd=%h err=%b, expected all 0",
                 i, gnt, valid_o, request_extmem, write_extmem, addr_extmem, w_data, err_spurious);
      end
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    req = 3'b001;
    tick();
    vec++;
    if (gnt !== 3'b001) begin bad++; $display("FAIL burst_gnt: gnt=%b expected 001", gnt); end
    vec++;
    if (request_extmem !== 1'b1 || addr_extmem !== 32'h10 || write_extmem !== 1'b0) begin
      bad++;
      $display("FAIL burst_port: req_ext=%b addr=%h wr=%b expected 1/00000010/0", request_extmem, addr_extmem, write_extmem);
    end
    for (int b = 0; b < 4; b++) begin
      valid_extmem = 1'b1;
      data_extmem  = 32'hD000 + 32'(b);
      last         = (b == 3) ? 3'b001 : 3'b000;
      #1;
      vec++;
      if (valid_o !== 3'b001 || rdata_o !== 32'hD000 + 32'(b)) begin
        bad++;
        $display("FAIL burst_beat%0d: valid_o=%b rdata=%h expected 001/%h", b, valid_o, rdata_o, 32'hD000 + 32'(b));
      end
      tick();
    end
    valid_extmem = 1'b0;
    last         = '0;
    req          = '0;
    #1;
    vec++;
    if (gnt !== 3'b000 || request_extmem !== 1'b0) begin
      bad++;
      $display("FAIL burst_release: gnt=%b req_ext=%b expected 000/0", gnt, request_extmem);
    end
`ifdef ARB_STATS_EN
    vec++;
    if (stat_beats[31:0] !== 32'd4) begin
      bad++;
      $display("FAIL stat_beats0: got %0d expected 4", stat_beats[31:0]);
    end
`endif
    tick();
    req = 3'b011;
    tick();
    vec++;
    if (gnt !== 3'b010) begin bad++; $display("FAIL ptr_after_release: gnt=%b expected 010", gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int unsigned owners [4] = '{0, 1, 2, 0};
    logic [N-1:0] exp;
    do_reset();
    req = 3'b111;
    tick();
    for (int o = 0; o < 4; o++) begin
      exp = N'(1) << owners[o];
      vec++;
      if (gnt !== exp || request_extmem !== 1'b1) begin
        bad++;
        $display("FAIL rr_handover%0d: gnt=%b req_ext=%b expected %b/1", o, gnt, request_extmem, exp);
      end
      for (int b = 0; b < 16; b++) begin
        valid_extmem = 1'b1;
        #1;
        vec++;
        if (gnt !== exp || valid_o !== exp) begin
          bad++;
          $display("FAIL rr_owner%0d_beat%0d: gnt=%b valid_o=%b expected %b", o, b, gnt, valid_o, exp);
        end
        tick();
      end
      valid_extmem = 1'b0;
      #1;
      vec++;
      if (gnt !== 3'b000 || request_extmem !== 1'b0) begin
        bad++;
        $display("FAIL rr_cap_release%0d: gnt=%b req_ext=%b expected 000/0", o, gnt, request_extmem);
      end
      tick();
      vec++;
      if (gnt !== 3'b000 || request_extmem !== 1'b0) begin
        bad++;
        $display("FAIL rr_gap_idle%0d: gnt=%b req_ext=%b expected 000/0", o, gnt, request_extmem);
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_write_mux();
    do_reset();
    addr_i  = {32'h0000_0300, 32'h0000_0100, 32'h0000_0010};
    wdata_i = {32'h3333_3333, 32'h0000_CAFE, 32'h1111_1111};
    wr      = 3'b010;
    req     = 3'b010;
    tick();
    vec++;
    if (addr_extmem !== 32'h100 || w_data !== 32'hCAFE || write_extmem !== 1'b1 || request_extmem !== 1'b1) begin
      bad++;
      $display("FAIL wr_mux: addr=%h wd=%h wr=%b req_ext=%b expected 00000100/0000cafe/1/1",
               addr_extmem, w_data, write_extmem, request_extmem);
    end
    valid_extmem = 1'b1;
    last         = 3'b010;
    #1;
    vec++;
    if (valid_o !== 3'b010) begin bad++; $display("FAIL wr_valid: valid_o=%b expected 010", valid_o); end
    tick();
    valid_extmem = 1'b0;
    last         = '0;
    req          = '0;
    #1;
    vec++;
    if (addr_extmem !== '0 || w_data !== '0 || write_extmem !== 1'b0) begin
      bad++;
      $display("FAIL wr_mux_quiet: addr=%h wd=%h wr=%b expected 0/0/0", addr_extmem, w_data, write_extmem);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    tick();
    vec++;
    if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_pre: err=%b expected 0", err_spurious); end
    valid_extmem = 1'b1;
    #1;
    vec++;
    if (valid_o !== 3'b000) begin bad++; $display("FAIL spur_valid_o: valid_o=%b expected 000", valid_o); end
    tick();
    valid_extmem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (err_spurious !== 1'b1 || gnt !== 3'b000) begin
        bad++;
        $display("FAIL spur_sticky%0d: err=%b gnt=%b expected 1/000", i, err_spurious, gnt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 3'b001;
    tick();
    for (int b = 0; b < 4; b++) begin
      valid_extmem = 1'b1;
      tick();
    end
    #1;
    vec++;
    if (valid_o !== 3'b001) begin bad++; $display("FAIL mid_beat5: valid_o=%b expected 001", valid_o); end
    rst = 1'b0;
    #1;
    vec++;
    if ({gnt, valid_o, request_extmem, addr_extmem, err_spurious} !== '0) begin
      bad++;
      $display("FAIL mid_reset_async: gnt=%b vo=%b req_ext=%b addr=%h err=%b expected 0",
               gnt, valid_o, request_extmem, addr_extmem, err_spurious);
    end
    valid_extmem = 1'b0;
    tick();
    vec++;
    if ({gnt, request_extmem, err_spurious} !== '0) begin
      bad++;
      $display("FAIL mid_reset_edge: gnt=%b req_ext=%b err=%b expected 0", gnt, request_extmem, err_spurious);
    end
    rst = 1'b1;
    req = 3'b100;
    tick();
    vec++;
    if (gnt !== 3'b100) begin bad++; $display("FAIL post_reset_only2: gnt=%b expected 100", gnt); end
    do_reset();
    req = 3'b101;
    tick();
    vec++;
    if (gnt !== 3'b001) begin bad++; $display("FAIL post_reset_prio0: gnt=%b expected 001", gnt); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_write_mux();
    test_spurious();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
